// File: rtl/fir_tap_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_tap_sched                                                 |
// | Purpose  : Per-sample MAC sequencer and single-port CMEM arbiter for the |
// |            FIR. Pops one FIFO sample per pass, walks tap addresses       |
// |            0..TAPS-1, strobes the ALU accumulator and lets host          |
// |            coefficient writes through only while no pass is running.    |
// | Options  : FIR_TAP_SCHED_STALL_CNT_EN adds a saturating 16-bit counter   |
// |            of host write cycles held off by a running pass.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fir_tap_sched #(
  parameter int TAPS    = 64,
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int OUT_CNT = 100,
  parameter int CW      = 7
) (
  input  logic          clk2,
  input  logic          rstn,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_o,
  output logic          imem_shift_o,
  input  logic          cload_i,
  input  logic [AW-1:0] caddr_i,
  input  logic [DW-1:0] cin_i,
  output logic          cwr_ack_o,
  output logic          cmem_cen_o,
  output logic          cmem_wen_o,
  output logic [AW-1:0] cmem_a_o,
  output logic [DW-1:0] cmem_d_o,
  output logic [AW-1:0] tap_addr_o,
  output logic          acc_clr_o,
  output logic          acc_en_o,
  output logic          acc_last_o,
  output logic          sample_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] sample_cnt_o
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam logic [2:0]    C_IDLE    = 3'd0;
  localparam logic [2:0]    C_LOAD    = 3'd1;
  localparam logic [2:0]    C_MAC     = 3'd2;
  localparam logic [2:0]    C_DRAIN   = 3'd3;
  localparam logic [2:0]    C_DONE    = 3'd4;
  localparam logic [AW-1:0] C_K_LAST  = AW'(TAPS - 1);
  localparam logic [AW-1:0] C_K_ONE   = AW'(1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(OUT_CNT);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sv_q;
  logic [CW-1:0] w_cnt_inc;
  logic          w_wr;

  // Host writes are only granted between passes; held off while in reset.
  assign w_wr      = cload_i && rstn && ((state_q == C_IDLE) || (state_q == C_DONE));
  assign w_cnt_inc = cnt_q + CW'(1);

  // State register.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) state_q <= C_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a pending host write wins over starting a pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (!cload_i && !fifo_empty_i) state_d = C_LOAD;
      C_LOAD:  state_d = C_MAC;
      C_MAC:   if (k_q == C_K_LAST) state_d = C_DRAIN;
      C_DRAIN: state_d = (w_cnt_inc == C_CNT_MAX) ? C_DONE : C_IDLE;
      C_DONE:  state_d = C_DONE;
      default: state_d = C_IDLE;
    endcase
  end

  // Tap index and sample count next values; k is held at 0 outside MAC.
  always_comb begin
    k_d   = '0;
    cnt_d = cnt_q;
    if ((state_q == C_MAC) && (k_q != C_K_LAST)) k_d = k_q + AW'(1);
    if ((state_q == C_DRAIN) && (cnt_q != C_CNT_MAX)) cnt_d = w_cnt_inc;
  end

  // Tap index, sample counter and the result-valid pulse registers.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      k_q   <= '0;
      cnt_q <= '0;
      sv_q  <= 1'b0;
    end else begin
      k_q   <= k_d;
      cnt_q <= cnt_d;
      sv_q  <= (state_q == C_DRAIN);
    end
  end

  // Outputs decoded from state; CMEM read data lags the address by one cycle,
  // so accumulation runs from the second MAC cycle through DRAIN.
  always_comb begin
    fifo_rd_o    = (state_q == C_LOAD);
    imem_shift_o = (state_q == C_LOAD);
    busy_o       = (state_q == C_LOAD) || (state_q == C_MAC) || (state_q == C_DRAIN);
    done_o       = (state_q == C_DONE);
    acc_en_o     = ((state_q == C_MAC) && (k_q != '0)) || (state_q == C_DRAIN);
    acc_clr_o    = (state_q == C_MAC) && (k_q == C_K_ONE);
    acc_last_o   = (state_q == C_DRAIN);
    cwr_ack_o    = w_wr;
    tap_addr_o   = k_q;
    cmem_cen_o   = 1'b1;
    cmem_wen_o   = 1'b1;
    cmem_a_o     = k_q;
    cmem_d_o     = '0;
    if (w_wr) begin
      cmem_cen_o = 1'b0;
      cmem_wen_o = 1'b0;
      cmem_a_o   = caddr_i;
      cmem_d_o   = cin_i;
    end else if (state_q == C_MAC) begin
      cmem_cen_o = 1'b0;
    end
  end

  assign sample_valid_o = sv_q;
  assign sample_cnt_o   = cnt_q;

`ifdef FIR_TAP_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles the host spends waiting on a running pass; saturating.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn)                                        stall_q <= '0;
    else if (cload_i && !w_wr && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_tap_sched                                              |
// | Purpose  : Scoreboard bench for fir_tap_sched: stimulus pushes expected  |
// |            events per kind, a negedge monitor pops and compares them.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fir_tap_sched;
  localparam int TAPS = 64, AW = 6, DW = 16, OUT_CNT = 100, CW = 7;

  typedef struct { int cyc; int val; } exp_t;

  logic clk2 = 1'b0, rstn = 1'b1, fifo_empty = 1'b1, cload = 1'b0;
  logic [AW-1:0] caddr = '0;
  logic [DW-1:0] cin = '0;
  logic fifo_rd, imem_shift, cwr_ack, cmem_cen, cmem_wen;
  logic [AW-1:0] cmem_a, tap_addr;
  logic [DW-1:0] cmem_d;
  logic acc_clr, acc_en, acc_last, sample_valid, busy, done;
  logic [CW-1:0] sample_cnt;
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fir_tap_sched #(.TAPS(TAPS), .AW(AW), .DW(DW), .OUT_CNT(OUT_CNT), .CW(CW)) dut (
    .clk2(clk2), .rstn(rstn), .fifo_empty_i(fifo_empty), .fifo_rd_o(fifo_rd),
    .imem_shift_o(imem_shift), .cload_i(cload), .caddr_i(caddr), .cin_i(cin),
    .cwr_ack_o(cwr_ack), .cmem_cen_o(cmem_cen), .cmem_wen_o(cmem_wen),
    .cmem_a_o(cmem_a), .cmem_d_o(cmem_d), .tap_addr_o(tap_addr),
    .acc_clr_o(acc_clr), .acc_en_o(acc_en), .acc_last_o(acc_last),
    .sample_valid_o(sample_valid), .busy_o(busy), .done_o(done),
    .sample_cnt_o(sample_cnt)
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk2 = ~clk2;

  int   cyc = 0;
  int   n_vec = 0, n_err = 0, exp_cnt = 0, exp_stall = 0;
  exp_t rd_q[$], mac_q[$], clr_q[$], last_q[$], sv_q[$], wr_q[$];

  always @(posedge clk2) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d, required none", nm, cyc);
  endtask

  // Monitor: every observable event must match the head of its queue.
  always @(negedge clk2) begin
    exp_t e;
    if (cwr_ack) begin
      if (wr_q.size() == 0) unexp("cwr_ack");
      else begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_bus", int'({cmem_wen, cmem_cen, cmem_a, cmem_d}), e.val);
      end
    end
    if (fifo_rd) begin
      if (rd_q.size() == 0) unexp("fifo_rd");
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_shift_busy", int'({imem_shift, busy}), e.val);
      end
    end
    if (!cmem_cen && cmem_wen) begin
      if (mac_q.size() == 0) unexp("mac_read");
      else begin
        e = mac_q.pop_front();
        check("mac_cycle", cyc, e.cyc);
        check("mac_addr_en", int'({tap_addr, cmem_a, acc_en, busy}), e.val);
      end
    end
    if (acc_en && !(!cmem_cen && cmem_wen) && !acc_last) unexp("acc_en");
    if (acc_clr) begin
      if (clr_q.size() == 0) unexp("acc_clr");
      else begin
        e = clr_q.pop_front();
        check("clr_cycle", cyc, e.cyc);
      end
    end
    if (acc_last) begin
      if (last_q.size() == 0) unexp("acc_last");
      else begin
        e = last_q.pop_front();
        check("last_cycle", cyc, e.cyc);
        check("last_en", int'(acc_en), e.val);
      end
    end
    if (sample_valid) begin
      if (sv_q.size() == 0) unexp("sample_valid");
      else begin
        e = sv_q.pop_front();
        check("sv_cycle", cyc, e.cyc);
        check("sv_count", int'(sample_cnt), e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  // Queue the full expected trace of one pass that starts next cycle.
  task automatic push_pass(input int c0);
    rd_q.push_back(mk(c0, 3));
    for (int k = 0; k < TAPS; k++)
      mac_q.push_back(mk(c0 + 1 + k, (k << 8) | (k << 2) | ((k != 0) ? 2 : 0) | 1));
    clr_q.push_back(mk(c0 + 2, 0));
  endtask

  // One sample pass; optional host write raised at C0+wr_at that must wait
  // for IDLE at C0+TAPS+2. Called in an IDLE cycle; returns in an IDLE cycle.
  task automatic do_sample(input int wr_at, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit together);
    int c0;
    c0 = cyc + 1;
    fifo_empty = 1'b0;
    push_pass(c0);
    last_q.push_back(mk(c0 + TAPS + 1, 1));
    exp_cnt++;
    sv_q.push_back(mk(c0 + TAPS + 2, exp_cnt));
    if (wr_at >= 0) wr_q.push_back(mk(c0 + TAPS + 2, (int'(a) << 16) | int'(d)));
    tick();
    fifo_empty = 1'b1;
    while (cyc < c0 + TAPS + 2) begin
      if (wr_at >= 0 && cyc == c0 + wr_at) begin
        cload = 1'b1;
        caddr = a;
        cin   = d;
      end
      tick();
    end
    if (wr_at >= 0) begin
      exp_stall += TAPS + 2 - wr_at;
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
      check("stall_cnt", int'(stall_cnt), exp_stall);
`endif
      if (together) fifo_empty = 1'b0;
      tick();
      cload = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctl"}, int'({fifo_rd, imem_shift, cwr_ack, acc_clr, acc_en, acc_last,
                               sample_valid, busy, done}), 0);
    check({nm, "_cmem"}, int'({cmem_cen, cmem_wen, cmem_a, tap_addr}), 32'h3 << (2 * AW));
    check({nm, "_cnt"}, int'(sample_cnt), 0);
`ifdef FIR_TAP_SCHED_STALL_CNT_EN
    check({nm, "_stall"}, int'(stall_cnt), 0);
`endif
  endtask

  initial begin
    int c0;
    // Reset with a write request present: it must not be acknowledged.
    #1 rstn = 1'b0;
    cload = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    cload = 1'b0;
    rstn  = 1'b1;
    tick();

    // 64 back-to-back coefficient writes in IDLE, no sample available.
    for (int i = 0; i < TAPS; i++) begin
      cload = 1'b1;
      caddr = AW'(i);
      cin   = DW'(16'hA000 + i * 7);
      wr_q.push_back(mk(cyc, (i << 16) | (16'hA000 + i * 7)));
      tick();
    end
    cload = 1'b0;
    tick();

    // Single pass, then a pass with a write raised at C10 plus a sample
    // arriving together with the deferred write.
    do_sample(-1, '0, '0, 1'b0);
    check("cnt_after_first", int'(sample_cnt), 1);
    do_sample(10, 6'd5, 16'h1234, 1'b1);
    do_sample(-1, '0, '0, 1'b0);
    check("cnt_after_third", int'(sample_cnt), 3);

    // Abort a pass at tap 30 with an asynchronous reset.
    c0 = cyc + 1;
    fifo_empty = 1'b0;
    push_pass(c0);
    tick();
    fifo_empty = 1'b1;
    while (cyc < c0 + 31) tick();
    rstn = 1'b0;
    rd_q.delete(); mac_q.delete(); clr_q.delete(); last_q.delete(); sv_q.delete();
    exp_cnt   = 0;
    exp_stall = 0;
    #1;
    check_reset_outputs("abort");
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // 100 samples from a clean restart; first holds a write for the whole pass.
    do_sample(0, 6'd9, 16'hBEEF, 1'b1);
    for (int s = 1; s < OUT_CNT; s++) do_sample(-1, '0, '0, 1'b0);
    check("done_flag", int'({done, busy}), 2);
    check("final_cnt", int'(sample_cnt), OUT_CNT);

    // DONE: sample on offer is never popped; writes still accepted.
    fifo_empty = 1'b0;
    repeat (40) tick();
    cload = 1'b1;
    caddr = 6'd33;
    cin   = 16'h5A5A;
    wr_q.push_back(mk(cyc, (33 << 16) | 16'h5A5A));
    tick();
    cload = 1'b0;
    repeat (40) tick();
    fifo_empty = 1'b1;
    check("done_hold", int'({done, busy}), 2);
    check("cnt_hold", int'(sample_cnt), OUT_CNT);

    repeat (3) tick();
    check("rd_left", rd_q.size(), 0);
    check("mac_left", mac_q.size(), 0);
    check("clr_left", clr_q.size(), 0);
    check("last_left", last_q.size(), 0);
    check("sv_left", sv_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
